// File: rtl/instr_exec_unit.sv
// instr_exec_unit: walks a range of instr_register entries through the read port,
// executes each opcode on its operands and streams results out on valid/ready.

package instr_register_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned RES_W = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4:0]              start_ptr,
  input  logic [5:0]              count,
  input  logic                    abort,
  output logic [4:0]              read_pointer,
  input  instruction_t            instruction_word,
  output logic signed [RES_W-1:0] result,
  output logic [3:0]              result_opc,
  output logic [4:0]              result_ptr,
  output logic                    result_err,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  address_t                ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0]        rem_q, rem_d;
  instruction_t            instr_q, instr_d;
  logic [4:0]              rd_ptr_d;
  logic signed [RES_W-1:0] result_d;
  logic [3:0]              opc_d;
  logic [4:0]              res_ptr_d;
  logic                    err_d, valid_d, busy_d, done_d;

  logic signed [RES_W-1:0] a_ext, b_ext, exec_res;
  logic                    exec_err;

  // Next sequential address, wrapping modulo DEPTH
  assign ptr_inc = address_t'((32'(ptr_q) + 32'd1) % DEPTH);

  // Datapath: signed arithmetic on sign-extended operands of the captured word
  always_comb begin
    a_ext    = {{(RES_W-OP_W){instr_q.op_a[OP_W-1]}}, instr_q.op_a};
    b_ext    = {{(RES_W-OP_W){instr_q.op_b[OP_W-1]}}, instr_q.op_b};
    exec_res = '0;
    exec_err = 1'b0;
    case (instr_q.opc)
      ZERO:  exec_res = '0;
      PASSA: exec_res = a_ext;
      PASSB: exec_res = b_ext;
      ADD:   exec_res = a_ext + b_ext;
      SUB:   exec_res = a_ext - b_ext;
      MULT:  exec_res = a_ext * b_ext;
      DIV: begin
        if (b_ext == '0) exec_err = 1'b1;
        else             exec_res = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) exec_err = 1'b1;
        else             exec_res = a_ext % b_ext;
      end
      default: exec_err = 1'b1;
    endcase
  end

  // Next-state and next-output logic; abort wins over any handshake
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    instr_d   = instr_q;
    rd_ptr_d  = read_pointer;
    result_d  = result;
    opc_d     = result_opc;
    res_ptr_d = result_ptr;
    err_d     = result_err;
    valid_d   = result_valid;
    done_d    = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_d  = FETCH;
              ptr_d    = start_ptr;
              rem_d    = count;
              rd_ptr_d = start_ptr;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        FETCH: begin
          instr_d = instruction_word;
          state_d = EXEC;
        end
        EXEC: begin
          result_d  = exec_res;
          opc_d     = instr_q.opc;
          res_ptr_d = ptr_q;
          err_d     = exec_err;
          valid_d   = 1'b1;
          state_d   = OUT;
        end
        OUT: begin
          if (result_valid && result_ready) begin
            valid_d = 1'b0;
            ptr_d   = ptr_inc;
            rem_d   = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = FETCH;
              rd_ptr_d = ptr_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      instr_q      <= '0;
      read_pointer <= '0;
      result       <= '0;
      result_opc   <= '0;
      result_ptr   <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      instr_q      <= instr_d;
      read_pointer <= rd_ptr_d;
      result       <= result_d;
      result_opc   <= opc_d;
      result_ptr   <= res_ptr_d;
      result_err   <= err_d;
      result_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Downstream consumer of instr_register: walks a range of stored instruction words through the register's read port, executes each opcode on its two operands, and presents results one at a time on a valid/ready output.
- Sits between instr_register and the result checker/scoreboard.
- Uses the instr_register_pkg types:
  - opcode_t is 4-bit: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
  - operand_t is signed 32-bit.
  - address_t is 5-bit.
  - instruction_t is {opc, op_a, op_b}.

Parameters:
- DEPTH, 32, number of instr_register entries; pointer wraps modulo DEPTH; must be a power of 2.
- RES_W, 64, result width; must be ≥ 2×32.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- start_ptr  in  5  first address to execute.
- count  in  6  number of instructions, 1..32; 0 means empty run.
- abort  in  1  synchronous cancel of the current run.
- read_pointer  out  5  address to instr_register.
- instruction_word  in  instruction_t  from instr_register; combinational read of read_pointer.
- result  out  RES_W  signed result.
- result_opc  out  4  opcode of the result.
- result_ptr  out  5  address the result came from.
- result_err  out  1  divide-by-zero or illegal opcode.
- result_valid  out  1  result fields valid.
- result_ready  in  1  consumer accepts.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; read_pointer=0; result=0; result_opc=0; result_ptr=0; result_err=0; result_valid=0; busy=0; done=0. Internal ptr and remaining counter are cleared. A reset mid-run discards the run; no done pulse.
- States: IDLE, FETCH, EXEC, OUT.
- IDLE:
  - start=1 and count≠0: latch ptr=start_ptr and remaining=count, go to FETCH.
  - start=1 and count=0: stay in IDLE, pulse done next cycle.
  - start while busy is ignored.
- FETCH: read_pointer=ptr. At the clock edge, capture instruction_word into an internal register, go to EXEC.
- EXEC: compute from the captured word and register into the result fields; result_ptr=ptr; result_valid=1 from the next cycle; go to OUT. All arithmetic is signed, operands sign-extended to RES_W:
  - ZERO→0
  - PASSA→a
  - PASSB→b
  - ADD→a+b
  - SUB→a−b
  - MULT→a×b (full 64-bit product)
  - DIV→a/b, truncating toward zero
  - MOD→a%b, remainder takes the sign of a
  - b=0 for DIV/MOD: result=0, result_err=1.
  - Opcodes 8..15: result=0, result_err=1.
  - result_err=0 otherwise.
- OUT:
  - Hold all result fields stable while result_valid=1 and result_ready=0.
  - On handshake (valid&ready): result_valid drops next cycle; ptr=(ptr+1) mod DEPTH; remaining−1.
  - If remaining was 1: go to IDLE and pulse done in that same cycle.
  - Otherwise: go to FETCH.
- Throughput: at most 1 result per 3 cycles. Latency from start to first result_valid is 3 cycles.
- Wrap-around: ptr wraps 31→0 with no error.
- abort=1 in any non-IDLE state: next cycle state=IDLE, result_valid=0, no done pulse. abort has priority over a simultaneous handshake, which is treated as not accepted.
- read_pointer holds its last value outside FETCH.

Test Plan:
1. Reset, then start_ptr=0, count=3 with entries {ADD,5,7}, {SUB,3,10}, {MULT,−4,6}, result_ready=1 → results 12, −7, −24 with result_ptr 0,1,2; done pulses once; busy low after the run.
2. Backpressure: result_ready=0 for 5 cycles on the first result → result, result_opc and result_ptr are stable and valid stays high; the result is accepted once ready rises; no duplicate result and no lost result.
3. {MULT, 0x7FFFFFFF, 0x7FFFFFFF} → result=0x3FFFFFFF00000001. {DIV,−7,2} → −3. {MOD,−7,2} → −1. {DIV,9,0} → result=0, result_err=1. Opcode 12 → result=0, result_err=1.
4. start_ptr=30, count=4 → result_ptr sequence 30, 31, 0, 1.
5. count=0 → done pulses next cycle and result_valid never rises. start asserted while busy → ignored.
6. abort during OUT with valid=1 and ready=1 → no handshake counted, IDLE next cycle, no done pulse. reset_n dropped during EXEC → all outputs at reset values immediately (asynchronously).
